// File: rtl/and_snina_pipe.sv
// Masked AND gadget (SNI + NINA): D+1 Boolean shares, each a (K+1)-bit repetition codeword.
// Stage 1 registers refreshed partial products; stage 2 compresses, checks codewords and gates release.
module and_snina_pipe #(
    parameter int unsigned D     = 1,
    parameter int unsigned K     = 1,
    parameter int unsigned CNT_W = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         port_in_valid,
    input  logic [(D+1)*(K+1)-1:0]       port_a,
    input  logic [(D+1)*(K+1)-1:0]       port_b,
    input  logic [D*(D+1)/2-1:0]         port_r,
    input  logic                         port_clear,
    output logic [(D+1)*(K+1)-1:0]       port_c,
    output logic                         port_out_valid,
    output logic [D:0]                   port_errorFlag,
    output logic                         port_fault,
    output logic [CNT_W-1:0]             port_fault_cnt
);

    localparam int unsigned S  = D + 1;
    localparam int unsigned W  = K + 1;
    localparam int unsigned UW = S * S * W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t         state;
    logic [UW-1:0]  u_d;
    logic [UW-1:0]  u_q;
    logic           v1;
    logic [S*W-1:0] c_d;
    logic [S-1:0]   e_d;
    logic           new_err;
    logic           release_ok;

    // Cross products a_i & b_j; off-diagonal terms share one fresh bit per unordered pair.
    for (genvar gi = 0; gi < S; gi++) begin : g_row
        for (genvar gj = 0; gj < S; gj++) begin : g_col
            logic [W-1:0] prod;
            assign prod = port_a[gi*W +: W] & port_b[gj*W +: W];
            if (gi == gj) begin : g_diag
                assign u_d[(gi*S+gj)*W +: W] = prod;
            end else begin : g_off
                localparam int unsigned LO = (gi < gj) ? gi : gj;
                localparam int unsigned HI = (gi < gj) ? gj : gi;
                localparam int unsigned RI = LO*S - (LO*(LO+1))/2 + HI - LO - 1;
                assign u_d[(gi*S+gj)*W +: W] = prod ^ {W{port_r[RI]}};
            end
        end
    end

    // Stage 1: partial-product registers load only on valid input.
    always_ff @(posedge clk) begin
        if (!reset) begin
            v1  <= 1'b0;
            u_q <= '0;
        end else begin
            v1 <= port_in_valid;
            if (port_in_valid) begin
                u_q <= u_d;
            end
        end
    end

    // Row compression and codeword consistency (valid codeword = all bits equal).
    always_comb begin
        c_d = '0;
        e_d = '0;
        for (int unsigned i = 0; i < S; i++) begin
            for (int unsigned j = 0; j < S; j++) begin
                c_d[i*W +: W] = c_d[i*W +: W] ^ u_q[(i*S+j)*W +: W];
                e_d[i] = e_d[i] | ~((&u_q[(i*S+j)*W +: W]) | ~(|u_q[(i*S+j)*W +: W]));
            end
        end
    end

    assign new_err    = v1 & (|e_d);
    assign release_ok = v1 & ~(|e_d) & (state != ST_FAULT);

    // Stage 2 outputs plus sticky fault FSM; a faulty or in-FAULT result is never released.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= ST_IDLE;
            port_c         <= '0;
            port_out_valid <= 1'b0;
            port_errorFlag <= '0;
            port_fault     <= 1'b0;
            port_fault_cnt <= '0;
        end else begin
            port_out_valid <= release_ok;
            port_errorFlag <= v1 ? e_d : '0;
            if (v1) begin
                port_c <= release_ok ? c_d : '0;
            end else if (state == ST_FAULT) begin
                port_c <= '0;
            end
            if (new_err && (port_fault_cnt != CNT_MAX)) begin
                port_fault_cnt <= port_fault_cnt + CNT_W'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (new_err) begin
                        state      <= ST_FAULT;
                        port_fault <= 1'b1;
                    end else if (v1) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (new_err) begin
                        state      <= ST_FAULT;
                        port_fault <= 1'b1;
                    end else if (!v1) begin
                        state <= ST_IDLE;
                    end
                end
                ST_FAULT: begin
                    // A new error in the clear cycle keeps the block locked.
                    if (port_clear && !new_err) begin
                        state      <= ST_IDLE;
                        port_fault <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    port_fault <= 1'b0;
                end
            endcase
        end
    end

endmodule
